// File: rtl/mem_arbiter.sv
// Shares one 16-bit big-endian memory between an instruction fetch port and a data port.
// state | meaning
// IDLE  | bus idle; arbitrate between pending fetch and data requests
// D_ACC | single data access in progress
// I_HI  | reading instruction halfword {tag,2'b00} into i_opcode[31:16]
// I_LO  | reading instruction halfword {tag,2'b10} into i_opcode[15:0]
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_pc,
    output logic [31:0] i_opcode,
    output logic        i_rdy,
    input  logic        d_assert,
    input  logic        d_cmd,
    input  logic [15:0] d_addr,
    input  logic        d_be0,
    input  logic        d_be1,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_rdy,
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [1:0]  m_be,
    output logic [15:0] m_wdata,
    input  logic [15:0] m_rdata,
    input  logic        m_ack
);
    typedef enum logic [1:0] {IDLE, D_ACC, I_HI, I_LO} state_t;

    state_t      state, state_nx;
    logic        last_data, last_data_nx;
    logic        valid, valid_nx;
    logic [13:0] tag, tag_nx;
    logic [31:0] i_opcode_nx;
    logic        d_rdy_nx;
    logic [15:0] d_rdata_nx;
    logic        m_req_nx, m_we_nx;
    logic [15:0] m_addr_nx, m_wdata_nx;
    logic [1:0]  m_be_nx;
    logic        data_pend, fetch_pend, grant_data, d_word, acked;
    logic        unused_pc;

    assign unused_pc  = ^i_pc[1:0];
    assign i_rdy      = valid && (tag == i_pc[15:2]);
    assign data_pend  = d_assert && !d_rdy;
    assign fetch_pend = !i_rdy;
    // On contention the requester not served last wins.
    assign grant_data = data_pend && (!fetch_pend || !last_data);
    assign d_word     = d_be0 && d_be1;
    assign acked      = m_req && m_ack;

    always_comb begin
        state_nx     = state;
        last_data_nx = last_data;
        valid_nx     = valid;
        tag_nx       = tag;
        i_opcode_nx  = i_opcode;
        d_rdy_nx     = 1'b0;
        d_rdata_nx   = d_rdata;
        m_req_nx     = m_req;
        m_we_nx      = m_we;
        m_addr_nx    = m_addr;
        m_be_nx      = m_be;
        m_wdata_nx   = m_wdata;
        case (state)
            IDLE: begin
                if (grant_data) begin
                    state_nx     = D_ACC;
                    last_data_nx = 1'b1;
                    m_req_nx     = 1'b1;
                    m_we_nx      = d_cmd;
                    m_addr_nx    = {d_addr[15:1], 1'b0};
                    m_be_nx      = d_word ? 2'b11 : (d_addr[0] ? 2'b01 : 2'b10);
                    m_wdata_nx   = d_word ? d_wdata : {d_wdata[7:0], d_wdata[7:0]};
                end else if (fetch_pend) begin
                    // Tag is captured now and stays invalid until the pair is complete.
                    state_nx     = I_HI;
                    last_data_nx = 1'b0;
                    valid_nx     = 1'b0;
                    tag_nx       = i_pc[15:2];
                    m_req_nx     = 1'b1;
                    m_we_nx      = 1'b0;
                    m_addr_nx    = {i_pc[15:2], 2'b00};
                    m_be_nx      = 2'b11;
                end
            end
            D_ACC: begin
                if (acked) begin
                    state_nx = IDLE;
                    d_rdy_nx = 1'b1;
                    m_req_nx = 1'b0;
                    m_we_nx  = 1'b0;
                    if (!m_we) begin
                        if (m_be == 2'b11)
                            d_rdata_nx = m_rdata;
                        else if (m_be[1])
                            d_rdata_nx = {8'h00, m_rdata[15:8]};
                        else
                            d_rdata_nx = {8'h00, m_rdata[7:0]};
                    end
                end
            end
            I_HI: begin
                if (acked) begin
                    state_nx              = I_LO;
                    i_opcode_nx[31:16]    = m_rdata;
                    m_addr_nx             = {tag, 2'b10};
                end
            end
            I_LO: begin
                if (acked) begin
                    state_nx           = IDLE;
                    i_opcode_nx[15:0]  = m_rdata;
                    valid_nx           = 1'b1;
                    m_req_nx           = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_data <= 1'b0;
            valid     <= 1'b0;
            tag       <= 14'd0;
            i_opcode  <= 32'd0;
            d_rdy     <= 1'b0;
            d_rdata   <= 16'd0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= 16'd0;
            m_be      <= 2'b00;
            m_wdata   <= 16'd0;
        end else begin
            state     <= state_nx;
            last_data <= last_data_nx;
            valid     <= valid_nx;
            tag       <= tag_nx;
            i_opcode  <= i_opcode_nx;
            d_rdy     <= d_rdy_nx;
            d_rdata   <= d_rdata_nx;
            m_req     <= m_req_nx;
            m_we      <= m_we_nx;
            m_addr    <= m_addr_nx;
            m_be      <= m_be_nx;
            m_wdata   <= m_wdata_nx;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory model with wait states, bus and read-data scoreboards.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_pc;
    logic [31:0] i_opcode;
    logic        i_rdy;
    logic        d_assert, d_cmd, d_be0, d_be1;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        d_rdy;
    logic        m_req, m_we, m_ack;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_be;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } bus_t;
    typedef struct packed {
        logic        rd;
        logic [15:0] val;
    } rd_t;

    bus_t       exp_bus[$];
    rd_t        exp_rd[$];
    logic [7:0] mem [0:65535];
    int         wait_states = 0;
    int         wcnt = 0;
    logic       nak = 1'b0;
    logic       spur = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pc(i_pc), .i_opcode(i_opcode), .i_rdy(i_rdy),
        .d_assert(d_assert), .d_cmd(d_cmd), .d_addr(d_addr),
        .d_be0(d_be0), .d_be1(d_be1), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rdy(d_rdy),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] fetch_exp(input logic [15:0] a);
        return {pat(a), pat(a + 16'd1), pat(a + 16'd2), pat(a + 16'd3)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_bus(input logic we, input logic [15:0] a, input logic [1:0] be,
                            input logic [15:0] wd);
        bus_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd;
        exp_bus.push_back(e);
    endtask

    task automatic push_rd(input logic rd, input logic [15:0] v);
        rd_t r;
        r.rd = rd; r.val = v;
        exp_rd.push_back(r);
    endtask

    // Memory model: ack after wait_states stalled cycles, big-endian lanes.
    assign m_ack   = (m_req && !nak && (wcnt >= wait_states)) || spur;
    assign m_rdata = {mem[m_addr], mem[m_addr + 16'd1]};

    always @(posedge clk) begin
        if (rst || !m_req || m_ack) wcnt <= 0;
        else                        wcnt <= wcnt + 1;
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        mem[16'h0008] = 8'h12; mem[16'h0009] = 8'h34;
        mem[16'h000A] = 8'h56; mem[16'h000B] = 8'h78;
        mem[16'hC000] = 8'hC0; mem[16'hC001] = 8'h00;
        forever begin
            @(posedge clk);
            if (m_req && m_ack && m_we) begin
                if (m_be[1]) mem[m_addr] = m_wdata[15:8];
                if (m_be[0]) mem[m_addr + 16'd1] = m_wdata[7:0];
            end
        end
    end

    // Bus and read-data scoreboard, plus request-hold check during stalls.
    initial begin
        bus_t e, prev;
        rd_t  r;
        logic stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (m_req && stall) chk("bus_hold", {m_we, m_addr, m_be, m_wdata}, prev);
            stall = m_req && !m_ack;
            prev  = {m_we, m_addr, m_be, m_wdata};
            if (m_req && m_ack) begin
                if (exp_bus.size() == 0) chk("bus_unexpected", 64'(exp_bus.size()), 1);
                else begin
                    e = exp_bus.pop_front();
                    chk("bus_we", m_we, e.we);
                    chk("bus_addr", m_addr, e.addr);
                    chk("bus_be", m_be, e.be);
                    if (e.we) chk("bus_wdata", m_wdata, e.wdata);
                end
            end
            if (d_rdy) begin
                if (exp_rd.size() == 0) chk("d_rdy_unexpected", 64'(exp_rd.size()), 1);
                else begin
                    r = exp_rd.pop_front();
                    if (r.rd) chk("d_rdata", d_rdata, r.val);
                end
            end
        end
    end

    task automatic d_req(input logic cmd, input logic [15:0] addr, input logic word,
                         input logic [15:0] wdata, input int lat);
        int n = 0;
        d_assert = 1'b1; d_cmd = cmd; d_addr = addr;
        d_be0 = word; d_be1 = word; d_wdata = wdata;
        do begin @(negedge clk); n++; end while (!d_rdy && n < 40);
        chk("d_rdy_seen", d_rdy, 1);
        chk("d_latency", n, lat);
        d_assert = 1'b0;
        @(negedge clk);
        chk("d_rdy_pulse", d_rdy, 0);
    endtask

    task automatic wait_fetch(input logic [31:0] exp);
        int n = 0;
        do begin @(negedge clk); n++; end while (!i_rdy && n < 60);
        chk("i_rdy_seen", i_rdy, 1);
        chk("i_opcode", i_opcode, exp);
    endtask

    initial begin
        rst = 1'b1; i_pc = 16'h0008;
        d_assert = 1'b0; d_cmd = 1'b0; d_addr = 16'h0; d_be0 = 1'b0; d_be1 = 1'b0; d_wdata = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_m_we", m_we, 0);
        chk("rst_m_be", m_be, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_d_rdy", d_rdy, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_i_rdy", i_rdy, 0);
        chk("rst_i_opcode", i_opcode, 0);

        // First fetch after reset: two halfword reads
        push_bus(1'b0, 16'h0008, 2'b11, 16'h0);
        push_bus(1'b0, 16'h000A, 2'b11, 16'h0);
        rst = 1'b0;
        wait_fetch(32'h12345678);
        chk("fetch_bus_drained", exp_bus.size(), 0);

        // Data accesses, zero-wait
        push_bus(1'b1, 16'hB000, 2'b01, 16'hABAB); push_rd(1'b0, 16'h0);
        d_req(1'b1, 16'hB001, 1'b0, 16'h00AB, 2);
        push_bus(1'b0, 16'hB000, 2'b01, 16'h0);    push_rd(1'b1, 16'h00AB);
        d_req(1'b0, 16'hB001, 1'b0, 16'h0, 2);
        push_bus(1'b0, 16'hC000, 2'b11, 16'h0);    push_rd(1'b1, 16'hC000);
        d_req(1'b0, 16'hC001, 1'b1, 16'h0, 2);
        push_bus(1'b0, 16'hC000, 2'b10, 16'h0);    push_rd(1'b1, 16'h00C0);
        d_req(1'b0, 16'hC000, 1'b0, 16'h0, 2);
        push_bus(1'b1, 16'h4000, 2'b11, 16'h1234); push_rd(1'b0, 16'h0);
        d_req(1'b1, 16'h4000, 1'b1, 16'h1234, 2);
        push_bus(1'b1, 16'h4002, 2'b10, 16'hCDCD); push_rd(1'b0, 16'h0);
        d_req(1'b1, 16'h4002, 1'b0, 16'h55CD, 2);
        push_bus(1'b0, 16'h4002, 2'b11, 16'h0);    push_rd(1'b1, 16'hCD7F);
        d_req(1'b0, 16'h4002, 1'b1, 16'h0, 2);

        // Two wait states stretch latency; read data holds across a later write
        wait_states = 2;
        push_bus(1'b0, 16'h4000, 2'b11, 16'h0);    push_rd(1'b1, 16'h1234);
        d_req(1'b0, 16'h4000, 1'b1, 16'h0, 4);
        wait_states = 0;
        push_bus(1'b1, 16'h4000, 2'b01, 16'h7777); push_rd(1'b0, 16'h0);
        d_req(1'b1, 16'h4001, 1'b0, 16'h0077, 2);
        chk("d_rdata_hold", d_rdata, 16'h1234);

        // Stray acks with no request outstanding
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("spur_m_req", m_req, 0);
            chk("spur_d_rdy", d_rdy, 0);
        end
        spur = 1'b0;
        push_bus(1'b0, 16'h4000, 2'b11, 16'h0);    push_rd(1'b1, 16'h1277);
        d_req(1'b0, 16'h4000, 1'b1, 16'h0, 2);

        // Continuous data demand against a missing fetch stream: grants alternate
        for (int k = 0; k < 3; k++) begin
            push_bus(1'b0, 16'h0100 + 16'(4 * k), 2'b11, 16'h0);
            push_bus(1'b0, 16'h0102 + 16'(4 * k), 2'b11, 16'h0);
            push_bus(1'b1, 16'h5000 + 16'(2 * k), 2'b11, 16'hA000 + 16'(k));
            push_rd(1'b0, 16'h0);
        end
        i_pc = 16'h0100;
        fork
            begin
                int na;
                for (int k = 0; k < 3; k++) begin
                    d_assert = 1'b1; d_cmd = 1'b1; d_be0 = 1'b1; d_be1 = 1'b1;
                    d_addr = 16'h5000 + 16'(2 * k); d_wdata = 16'hA000 + 16'(k);
                    na = 0;
                    do begin @(negedge clk); na++; end while (!d_rdy && na < 60);
                    chk("alt_d_rdy", d_rdy, 1);
                end
                d_assert = 1'b0;
            end
            begin
                int nf;
                for (int k = 0; k < 3; k++) begin
                    nf = 0;
                    do begin @(negedge clk); nf++; end while (!i_rdy && nf < 60);
                    chk("alt_i_rdy", i_rdy, 1);
                    chk("alt_i_opcode", i_opcode, fetch_exp(16'h0100 + 16'(4 * k)));
                    if (k < 2) i_pc = i_pc + 16'd4;
                end
            end
        join
        @(negedge clk);
        chk("alt_bus_drained", exp_bus.size(), 0);

        // i_pc moves during I_HI: old pair completes, then refetch
        push_bus(1'b0, 16'h0010, 2'b11, 16'h0);
        push_bus(1'b0, 16'h0012, 2'b11, 16'h0);
        push_bus(1'b0, 16'h0020, 2'b11, 16'h0);
        push_bus(1'b0, 16'h0022, 2'b11, 16'h0);
        i_pc = 16'h0010;
        @(negedge clk);
        chk("chg_in_fetch", m_req, 1);
        i_pc = 16'h0020;
        wait_fetch(fetch_exp(16'h0020));
        chk("chg_bus_drained", exp_bus.size(), 0);

        // Reset during a stalled data access
        nak = 1'b1;
        d_assert = 1'b1; d_cmd = 1'b0; d_addr = 16'hC000; d_be0 = 1'b1; d_be1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nak_m_req", m_req, 1);
        end
        rst = 1'b1; d_assert = 1'b0; nak = 1'b0;
        @(negedge clk);
        chk("abort_m_req", m_req, 0);
        chk("abort_d_rdy", d_rdy, 0);
        chk("abort_i_rdy", i_rdy, 0);
        push_bus(1'b0, 16'h0020, 2'b11, 16'h0);
        push_bus(1'b0, 16'h0022, 2'b11, 16'h0);
        rst = 1'b0;
        wait_fetch(fetch_exp(16'h0020));
        chk("end_bus_drained", exp_bus.size(), 0);
        chk("end_rd_drained", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, checks %0d", n_chk);
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 SHALL have no parameters; all widths are fixed as listed.
REQ-003 Ports, in this order (name, direction, width, meaning):
 - clk  in  1  clock
 - rst  in  1  synchronous active-high reset
 - i_pc  in  16  core fetch byte address; bits [1:0] ignored
 - i_opcode  out  32  fetched instruction pair
 - i_rdy  out  1  i_opcode valid for the current i_pc
 - d_assert  in  1  core data request
 - d_cmd  in  1  1=write, 0=read
 - d_addr  in  16  data byte address
 - d_be0, d_be1  in  1 each  both high = 16-bit word access, otherwise byte access
 - d_wdata  in  16  write data
 - d_rdata  out  16  read data
 - d_rdy  out  1  one-cycle completion pulse
 - m_req  out  1  backing-memory request
 - m_we  out  1  backing-memory write enable
 - m_addr  out  16  backing-memory byte address, bit 0 always 0
 - m_be  out  2  lane enables; [1]=bits 15:8 (even byte), [0]=bits 7:0 (odd byte)
 - m_wdata  out  16  backing-memory write data
 - m_rdata  in  16  backing-memory read data
 - m_ack  in  1  backing-memory completion, valid only while m_req=1

Function
REQ-004 SHALL share one 16-bit big-endian memory between the instruction port and the data port.
REQ-005 States: IDLE, D_ACC, I_HI, I_LO.
REQ-006 Fetch tag: a valid bit plus tag[13:0]. i_rdy = valid & (tag == i_pc[15:2]), combinational.
REQ-007 A fetch is pending when i_rdy=0.
REQ-008 IDLE grant rules:
 - data is pending when d_assert=1 and d_rdy=0;
 - with only one requester pending, grant it;
 - with both pending, grant the requester not served last (last-grant flag, reset value = instruction);
 - a data grant goes to D_ACC, a fetch grant goes to I_HI.
REQ-009 At the grant edge, SHALL capture the request fields:
 - data grant: d_addr, d_cmd, byte/word mode, d_wdata;
 - fetch grant: i_pc[15:2].
REQ-010 While m_req=1, SHALL hold m_addr, m_we, m_be and m_wdata stable until m_ack=1 is sampled; m_req is registered and rises on the edge after the grant.
REQ-011 Word data access:
 - m_addr = {addr[15:1],0}, m_be = 11;
 - write m_wdata = d_wdata;
 - read d_rdata = m_rdata.
REQ-012 Byte data access:
 - m_addr = {addr[15:1],0}; m_be = 10 when addr[0]=0, 01 when addr[0]=1;
 - write: m_wdata = {d_wdata[7:0], d_wdata[7:0]};
 - read: d_rdata = {8'h00, selected lane}.
REQ-013 In D_ACC, on the edge where m_ack=1:
 - d_rdy rises for exactly one cycle;
 - d_rdata is registered and then held until the next data completion;
 - m_req drops and the FSM returns to IDLE.
REQ-014 Data latency with a zero-wait memory (m_ack=1 in the first m_req cycle): d_assert sampled at edge N, m_req=1 in cycle N+1, d_rdy=1 in cycle N+2.
REQ-015 The core holds d_assert and the data fields stable until d_rdy. No new data grant occurs in the cycle d_rdy=1.
REQ-016 I_HI reads {tag,2'b00} into i_opcode[31:16], then goes to I_LO. I_LO reads {tag,2'b10} into i_opcode[15:0], sets valid=1, then returns to IDLE.
REQ-017 A fetch pair is never interrupted. A data request arriving during I_HI or I_LO waits for IDLE.
REQ-018 If i_pc changes during a fetch:
 - the pair completes and the tag holds the captured address;
 - the resulting mismatch causes a refetch through normal arbitration.
REQ-019 Writes do not invalidate the fetch tag; self-modifying code is unsupported.
REQ-020 m_ack while m_req=0 SHALL be ignored.

Reset
REQ-021 Synchronous rst=1 SHALL:
 - force IDLE;
 - drive m_req, m_we, d_rdy and valid to 0, and m_be to 00;
 - clear i_opcode, d_rdata and m_wdata to 0, m_addr to 0;
 - set last-grant to instruction.
REQ-022 rst mid-transaction SHALL abandon the access with no d_rdy pulse and no tag update; m_req is 0 in the cycle after rst is sampled.

Verification
REQ-023 Zero-wait memory, fetch at i_pc=0x0008, mem[0x0008..0x000B]=12 34 56 78 -> two m_req reads (0x0008, 0x000A), then i_rdy=1, i_opcode=0x12345678.
REQ-024 Byte write d_addr=0xB001, d_wdata=0x00AB -> m_be=01, m_wdata=0xABAB, d_rdy pulse 2 cycles after d_assert; a byte read of 0xB001 -> d_rdata=0x00AB.
REQ-025 Word read d_addr=0xC001 with mem[0xC000]=C0 00 -> m_addr=0xC000, m_be=11, d_rdata=0xC000.
REQ-026 d_assert held high continuously while i_pc misses -> grants alternate data/fetch-pair/data; both ports progress.
REQ-027 i_pc changed from 0x0010 to 0x0020 during I_HI -> pair for 0x0010 completes, i_rdy stays 0, refetch of 0x0020 follows, then i_rdy=1.
REQ-028 m_ack held low 3 cycles during D_ACC, rst asserted -> m_req=0 next cycle, no d_rdy pulse, i_rdy=0.
